// File: rtl/alt_vipcti130_is2vid_sync_generator.sv
// Output-side video timing generator: fixed raster, programmable sync polarity, pixel pull from stream.
// Latency: 1 clk from counter value to every vid_* pin; pix_ready is combinational from state/counters.
// Backpressure: none on timing; the raster never stalls, and a missing pixel in the active region outputs 0 and sets sticky underflow.
//
// Ports:
//   clk, rst                       pixel clock, synchronous active-high reset
//   enable                         run request; a frame in progress always completes
//   pix_data/pix_valid/pix_ready   incoming pixel stream (consumed when valid & ready)
//   underflow_clr                  clears the sticky underflow flag (a new miss wins)
//   vid_data/vid_datavalid         video pixel and active-region marker
//   vid_hsync/vid_vsync            syncs, active level selected by SYNC_POL
//   vid_sof                        1-clk pulse with the first active pixel of a frame
//   underflow                      sticky: active pixel needed while pix_valid was 0
module alt_vipcti130_is2vid_sync_generator #(
  parameter int DATA_W   = 24,
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              underflow_clr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_datavalid,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_sof,
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             POL        = 1'(SYNC_POL);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;

  logic running;
  logic line_end;
  logic frame_end;
  logic hs_act;
  logic vs_act;
  logic de;

  assign running   = (state_q == RUN);
  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);

  // vsync uses whole lines, so its edges land on h=0 automatically.
  assign hs_act = running && (h_q >= HS_START) && (h_q < HS_END);
  assign vs_act = running && (v_q >= VS_START) && (v_q < VS_END);
  assign de     = running && (h_q < H_ACT_END) && (v_q < V_ACT_END);

  assign pix_ready = de;

  // Stopping is only allowed on the frame boundary so a frame is never truncated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (frame_end && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters sit at 0 in IDLE, so the first RUN clock presents h=0, v=0.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      h_q <= '0;
      v_q <= '0;
    end else if (line_end) begin
      h_q <= '0;
      v_q <= frame_end ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_data      <= '0;
      vid_datavalid <= 1'b0;
      vid_hsync     <= ~POL;
      vid_vsync     <= ~POL;
      vid_sof       <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      vid_datavalid <= de;
      vid_hsync     <= ~(hs_act ^ POL);
      vid_vsync     <= ~(vs_act ^ POL);
      vid_sof       <= de && (h_q == '0) && (v_q == '0);
      // A missing active pixel shows as black rather than stalling the raster.
      vid_data      <= (de && pix_valid) ? pix_data : '0;
      if (de && !pix_valid) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
